data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle data memory: word-organised RAM with a valid/ready request port and fixed-latency response pipeline for the MEM stage. Adds true sub-word stores (byte-lane merge), alignment/range fault reporting, configurable read latency and a post-reset clear sweep, with a busy flag so the pipeline stalls until the sweep finishes.

Parameters:
DEPTH_LOG2, 12, log2 of word count (4096 words = 16 KiB).
READ_LATENCY, 1, cycles from request acceptance to response; legal 1..4.
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined, ready immediately.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
reqValid  input  1  request present.
reqReady  output  1  block accepts request this cycle.
reqWrite  input  1  1 = store, 0 = load.
reqWidth  input  2  access width code (package constants).
reqSigned  input  1  sign-extend sub-word loads.
reqAddr  input  32  byte address.
reqWData  input  32  store data; sub-word data in low bits.
rspValid  output  1  response valid, one cycle pulse per request.
rspRData  output  32  load data, extended; 0 for stores and faults.
rspFault  output  1  request faulted; no memory side effect.
busy  output  1  clear sweep in progress.
debugPC  input  32  PC of requesting instruction, used for trace only.

Behaviour:
- Reset (async, reset=1): state <= CLEAR if CLEAR_ON_RESET else RUN; sweep counter <= 0; all response pipeline stages invalidated; rspValid=0, rspRData=0, rspFault=0; busy=CLEAR_ON_RESET; reqReady=0. RAM contents themselves are not asynchronously reset.
- FSM: CLEAR -> writes word[counter]=0, counter+1 per cycle; at counter=2^DEPTH_LOG2-1 writes last word and moves to RUN next edge. RUN is terminal until reset. Reset asserted mid-sweep restarts sweep at 0.
- reqReady = (state==RUN). Accept = reqValid && reqReady; at most one request per cycle, no backpressure on responses.
- Every accepted request yields exactly one response with rspValid high exactly READ_LATENCY cycles after the accepting edge; responses in order.
- Word index = reqAddr[DEPTH_LOG2+1:2]. Range fault if reqAddr[31:DEPTH_LOG2+2] != 0.
- Width: WORD needs addr[1:0]=0; HALF needs addr[0]=0; BYTE any; code 2'b11 reserved -> fault.
- Little-endian lanes: byte offset k -> bits [8k+7:8k]; half at addr[1]=1 -> [31:16].
- Stores: commit at accepting edge, only addressed lanes written (byte/half: reqWData[7:0]/[15:0] replicated to the lane, byte-enable masks rest). Faulting store writes nothing.
- Loads: word read at accepting edge; lane select + zero/sign extension per reqSigned; extended value travels down the pipeline.
- Read-after-write: load accepted the cycle after a store to the same word returns merged new data. No same-cycle conflict exists.
- Fault response: rspFault=1, rspRData=0; non-fault: rspFault=0.

Optional Feature:
DM_TRACE_EN: when defined, each committed store prints "@<debugPC>: *<reqAddr> <= <merged word>" via $display, and each fault prints "@<debugPC>: fault <reqAddr> w<reqWidth>". When undefined no display statements are compiled; functional behaviour identical.

Decomposition:
- Shared constants package: width codes MEM_W_WORD=2'b00, MEM_W_HALF=2'b01, MEM_W_BYTE=2'b10, MEM_W_RSVD=2'b11; FSM state encodings CLEAR/RUN.
- Sub-module dm_lane_unit (combinational): byte-enable + store-data replication from width/offset, and load lane select + extension. Keeps the top as FSM, RAM and latency pipeline.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH_LOG2=4 -> busy=1, reqReady=0 for 16 cycles, then reqReady=1; word load from 0x3C returns 0x00000000.
- Store word 0x11223344 @0x10, store byte 0xAA @0x12, load word @0x10 -> 0x11AA3344 after READ_LATENCY cycles, rspFault=0.
- Load half @0x12 signed from word 0x8001_7FFF -> 0xFFFF8001; unsigned -> 0x00008001; byte @0x11 signed -> 0x0000007F.
- Misaligned word load @0x06, half store @0x03, width 2'b11 -> each rspFault=1, rspRData=0; follow-up word load confirms memory unchanged.
- READ_LATENCY=3, back-to-back loads to 0x0,0x4,0x8 on consecutive cycles -> three consecutive rspValid pulses starting 3 cycles after first accept, in order.
- Assert reset mid-sweep and mid-pipeline -> rspValid drops immediately, no stale response emerges later, sweep restarts at word 0.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared constants for the data memory controller: access width codes
// and the clear/run controller states.
package data_memory_ctrl_pkg;

    localparam logic [1:0] MEM_W_WORD = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_BYTE = 2'b10;
    localparam logic [1:0] MEM_W_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dm_state_e;

endpackage

// File: rtl/data_memory_ctrl_lane_unit.sv
// Byte-lane logic: store byte enables and data replication, load lane
// select with zero/sign extension, and alignment fault detection.
module dm_lane_unit
    import data_memory_ctrl_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_align_fault
);

    logic [31:0] w_sh;

    assign w_sh = i_rword >> {i_off, 3'b000};

    always_comb begin
        o_be          = 4'b0000;
        o_wdata       = i_wdata;
        o_rdata       = '0;
        o_align_fault = 1'b0;
        unique case (i_width)
            MEM_W_WORD: begin
                o_be          = 4'b1111;
                o_rdata       = i_rword;
                o_align_fault = |i_off;
            end
            MEM_W_HALF: begin
                o_be          = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata       = {2{i_wdata[15:0]}};
                o_rdata       = {{16{i_signed & w_sh[15]}},
                                 w_sh[15:0]};
                o_align_fault = i_off[0];
            end
            MEM_W_BYTE: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_sh[7]}}, w_sh[7:0]};
            end
            MEM_W_RSVD: begin
                o_align_fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data RAM: post-reset clear sweep, byte-lane stores, fixed
// latency responses. Define DM_TRACE_EN to print store/fault trace lines.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2     = 12,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqWidth,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    output logic [31:0] rspRData,
    output logic        rspFault,
    output logic        busy,
    input  logic [31:0] debugPC
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam dm_state_e RST_STATE =
        (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [31:0]           r_mem [WORDS];
    dm_state_e             r_state;
    dm_state_e             w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_clr_cnt;
    logic [DEPTH_LOG2-1:0] w_clr_cnt_nxt;
    logic                  w_clr_we;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_rword;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_rep;
    logic [31:0]           w_rdata_ext;
    logic                  w_align_fault;
    logic                  w_range_fault;
    logic                  w_fault;
    logic                  w_accept;
    logic                  w_store;
    logic                  w_load;

    logic [READ_LATENCY-1:0] r_pv;
    logic [READ_LATENCY-1:0] r_pf;
    logic [31:0]             r_pd [READ_LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_clr_we      = 1'b1;
            w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            if (&r_clr_cnt)
                w_state_nxt = ST_RUN;
        end
    end

    assign reqReady = (r_state == ST_RUN) && !reset;
    assign busy     = (r_state == ST_CLEAR);

    assign w_idx         = reqAddr[DEPTH_LOG2+1:2];
    assign w_rword       = r_mem[w_idx];
    assign w_range_fault = |reqAddr[31:DEPTH_LOG2+2];
    assign w_fault       = w_range_fault | w_align_fault;
    assign w_accept      = reqValid && reqReady;
    assign w_store       = w_accept && reqWrite && !w_fault;
    assign w_load        = w_accept && !reqWrite && !w_fault;

    dm_lane_unit u_lane (
        .i_width       (reqWidth),
        .i_off         (reqAddr[1:0]),
        .i_signed      (reqSigned),
        .i_wdata       (reqWData),
        .i_rword       (w_rword),
        .o_be          (w_be),
        .o_wdata       (w_wdata_rep),
        .o_rdata       (w_rdata_ext),
        .o_align_fault (w_align_fault)
    );

    // RAM contents deliberately have no reset; the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pv <= '0;
            r_pf <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                r_pd[i] <= '0;
        end else begin
            r_pv[0] <= w_accept;
            r_pf[0] <= w_accept && w_fault;
            r_pd[0] <= w_load ? w_rdata_ext : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pf[i] <= r_pf[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign rspValid = r_pv[READ_LATENCY-1];
    assign rspFault = r_pf[READ_LATENCY-1];
    assign rspRData = r_pd[READ_LATENCY-1];

`ifdef DM_TRACE_EN
    logic [31:0] w_merged;

    always_comb begin
        w_merged = w_rword;
        for (int b = 0; b < 4; b++)
            if (w_be[b])
                w_merged[8*b +: 8] = w_wdata_rep[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_store)
            $display("@%08h: *%08h <= %08h",
                     debugPC, reqAddr, w_merged);
        if (w_accept && w_fault)
            $display("@%08h: fault %08h w%0d",
                     debugPC, reqAddr, reqWidth);
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^debugPC;
`endif

endmodule
